mul_rr_scheduler: RTL

Round-robin scheduler that shares one pipelined multiplier among `NUM_REQ` requesters in the PE datapath. Each requester offers an operand pair over a valid/ready handshake. The block grants one pair per cycle, drives the multiplier's operand and enable inputs from registers, and tracks each grant's requester ID through the multiplier latency. It steers every product back to the requester that issued it.

---
 rtl/mul_rr_scheduler.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/mul_rr_scheduler.sv
// mul_rr_scheduler
//   Shares one pipelined multiplier among NUM_REQ requesters. A combinational
//   round-robin arbiter grants at most one operand pair per cycle. The granted
//   pair is registered onto the multiplier inputs. The requester ID rides a
//   tag pipeline that is cycle-aligned with the multiplier output, so each
//   product is steered back to the requester that issued it.
//
// Ports
//   CLK, RESET_N       clock, asynchronous active-low reset
//   SCHED_EN           1 = grants allowed, 0 = stop granting and drain
//   REQ_VALID/READY    per-requester handshake (READY is one-hot or zero)
//   REQ_MUL_0/1        packed operands, requester i at [i*W +: W]
//   MUL_ENABLE, MUL_0/1  registered multiplier inputs
//   MUL_OUT(_VALID)    multiplier result
//   RSP_VALID/DATA     one-hot result strobe and shared product bus
//   BUSY               grant registered or any tag in flight
//   ERR                sticky tag/valid misalignment flag
module mul_rr_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int WIDTH_0     = 16,
  parameter int WIDTH_1     = 16,
  parameter int WIDTH_OUT   = 48,
  parameter int MUL_LATENCY = 2
) (
  input  logic                       CLK,
  input  logic                       RESET_N,
  input  logic                       SCHED_EN,
  input  logic [NUM_REQ-1:0]         REQ_VALID,
  output logic [NUM_REQ-1:0]         REQ_READY,
  input  logic [NUM_REQ*WIDTH_0-1:0] REQ_MUL_0,
  input  logic [NUM_REQ*WIDTH_1-1:0] REQ_MUL_1,
  output logic                       MUL_ENABLE,
  output logic [WIDTH_0-1:0]         MUL_0,
  output logic [WIDTH_1-1:0]         MUL_1,
  input  logic [WIDTH_OUT-1:0]       MUL_OUT,
  input  logic                       MUL_OUT_VALID,
  output logic [NUM_REQ-1:0]         RSP_VALID,
  output logic [WIDTH_OUT-1:0]       RSP_DATA,
  output logic                       BUSY,
  output logic                       ERR
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int NST = MUL_LATENCY + 1;

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

  state_t               state_q, state_d;
  logic [IDW-1:0]       ptr_q, ptr_d;
  logic                 mul_en_q;
  logic [WIDTH_0-1:0]   mul0_q;
  logic [WIDTH_1-1:0]   mul1_q;
  logic [NST-1:0]       tag_vld_q;
  logic [IDW-1:0]       tag_id_q [NST];
  logic                 err_q;

  logic                 gnt_found;
  logic [IDW-1:0]       gnt_id;
  logic [WIDTH_0-1:0]   sel0;
  logic [WIDTH_1-1:0]   sel1;
  logic                 in_flight;

  assign in_flight = mul_en_q | (|tag_vld_q);

  // Round-robin search starting at ptr_q; only ACTIVE with SCHED_EN high may grant,
  // so a falling SCHED_EN blocks the grant in the same cycle.
  always_comb begin
    int idx;
    gnt_found = 1'b0;
    gnt_id    = '0;
    idx       = 0;
    if (state_q == ACTIVE && SCHED_EN) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = int'(ptr_q) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (!gnt_found && REQ_VALID[idx]) begin
          gnt_found = 1'b1;
          gnt_id    = IDW'(idx);
        end
      end
    end
  end

  always_comb begin
    REQ_READY = '0;
    if (gnt_found) REQ_READY[gnt_id] = 1'b1;
    ptr_d = ptr_q;
    if (gnt_found) ptr_d = (gnt_id == IDW'(NUM_REQ - 1)) ? '0 : gnt_id + IDW'(1);
    sel0 = REQ_MUL_0[gnt_id*WIDTH_0 +: WIDTH_0];
    sel1 = REQ_MUL_1[gnt_id*WIDTH_1 +: WIDTH_1];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (SCHED_EN) state_d = ACTIVE;
      ACTIVE:  if (!SCHED_EN) state_d = in_flight ? DRAIN : IDLE;
      DRAIN: begin
        if (SCHED_EN)        state_d = ACTIVE;
        else if (!in_flight) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage 0: multiplier inputs and tag stage 0 capture the granted pair.
  // Tag stages 1..MUL_LATENCY shift in step with the multiplier pipeline.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      mul_en_q  <= 1'b0;
      mul0_q    <= '0;
      mul1_q    <= '0;
      tag_vld_q <= '0;
      err_q     <= 1'b0;
      for (int s = 0; s < NST; s++) tag_id_q[s] <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      mul_en_q  <= gnt_found;
      if (gnt_found) begin
        mul0_q <= sel0;
        mul1_q <= sel1;
      end
      tag_vld_q[0] <= gnt_found;
      tag_id_q[0]  <= gnt_id;
      for (int s = 1; s < NST; s++) begin
        tag_vld_q[s] <= tag_vld_q[s-1];
        tag_id_q[s]  <= tag_id_q[s-1];
      end
      // A product without a matching tag (or a tag without a product) means
      // the multiplier and this block lost alignment; latch it until reset.
      err_q <= err_q | (MUL_OUT_VALID ^ tag_vld_q[NST-1]);
    end
  end

  // Response: last tag stage lines up with MUL_OUT_VALID.
  always_comb begin
    RSP_VALID = '0;
    if (MUL_OUT_VALID && tag_vld_q[NST-1]) RSP_VALID[tag_id_q[NST-1]] = 1'b1;
  end

  assign RSP_DATA   = MUL_OUT;
  assign MUL_ENABLE = mul_en_q;
  assign MUL_0      = mul0_q;
  assign MUL_1      = mul1_q;
  assign BUSY       = in_flight;
  assign ERR        = err_q;

endmodule
